counter_seq: RTL and testbench

COUNTER_SEQ -- requirements
Module: counter_seq

---
 rtl/counter_seq_pkg.sv | 6 +
 rtl/counter_seq_if.sv | 18 +
 rtl/counter_core.sv | 18 +
 rtl/counter_seq.sv | 62 ++++++
 tb/tb_counter_seq.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: shared state encoding and default sizes for the sequenced counter
package counter_seq_pkg;
   localparam int WIDTH = 3;
   localparam int WRAP_MAX = 15;
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
endpackage

// File: rtl/counter_seq_if.sv
// counter_seq_if: control inputs and count/status outputs of the sequenced counter
interface counter_seq_if;
   import counter_seq_pkg::*;
   logic start;
   logic stop;
   logic step;
   logic dir;
   logic oneshot;
   logic [WIDTH-1:0] limit;
   logic Q0;
   logic Q1;
   logic Q2;
   logic busy;
   logic done;
   logic [3:0] wraps;
   modport master (output start, stop, step, dir, oneshot, limit, input Q0, Q1, Q2, busy, done, wraps);
   modport slave (input start, stop, step, dir, oneshot, limit, output Q0, Q1, Q2, busy, done, wraps);
endinterface

// File: rtl/counter_core.sv
// counter_core: loadable up/down count register, load taking priority over enable
module counter_core #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dir,
   output logic [WIDTH-1:0] count
);
   // count register: load wins, otherwise step one in the requested direction
   always_ff @(posedge clk or posedge rst)
      if (rst) count <= '0;
      else if (load) count <= load_val;
      else if (en) count <= dir ? count - 1'b1 : count + 1'b1;
endmodule

// File: rtl/counter_seq.sv
// counter_seq: start/stop/step sequenced counter with terminal detect and wrap tally
module counter_seq #(
   parameter int WIDTH = counter_seq_pkg::WIDTH,
   parameter int WRAP_MAX = counter_seq_pkg::WRAP_MAX
) (
   input logic clk,
   input logic rst,
   counter_seq_if.slave bus
);
   import counter_seq_pkg::*;
   state_t state, state_n;
   logic dir_l, oneshot_l, done;
   logic [WIDTH-1:0] limit_l, count, load_val, term_val;
   logic relatch, abort, advance, terminal, load, en;
   logic [3:0] wraps;
   counter_core #(.WIDTH(WIDTH)) u_core (
      .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .dir(dir_l), .count(count)
   );
   // decode: a terminal advance reloads (continuous) or freezes (oneshot) instead of stepping
   always_comb begin
      relatch = (state == IDLE || state == DONE) && bus.start;
      abort = state == PAUSE && bus.stop;
      advance = (state == RUN && !bus.stop) || (state == PAUSE && !bus.stop && !bus.start && bus.step);
      term_val = dir_l ? '0 : limit_l;
      terminal = advance && count == term_val;
      load = relatch || abort || (terminal && !oneshot_l);
      load_val = relatch ? (bus.dir ? bus.limit : '0) : abort ? '0 : (dir_l ? limit_l : '0);
      en = advance && !terminal;
      state_n = state;
      case (state)
         IDLE, DONE: state_n = bus.start ? RUN : state;
         RUN: state_n = bus.stop ? PAUSE : (terminal && oneshot_l) ? DONE : RUN;
         PAUSE: state_n = bus.stop ? IDLE : bus.start ? RUN : (terminal && oneshot_l) ? DONE : PAUSE;
         default: state_n = IDLE;
      endcase
   end
   // state, start-time latches, done pulse and saturating wrap tally
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         dir_l <= 1'b0;
         oneshot_l <= 1'b0;
         limit_l <= '0;
         done <= 1'b0;
         wraps <= '0;
      end else begin
         state <= state_n;
         done <= terminal;
         if (relatch) begin
            dir_l <= bus.dir;
            oneshot_l <= bus.oneshot;
            limit_l <= bus.limit;
         end
         wraps <= relatch ? '0 : (terminal && wraps != 4'(WRAP_MAX)) ? wraps + 1'b1 : wraps;
      end
   assign bus.Q0 = count[0];
   assign bus.Q1 = count[1];
   assign bus.Q2 = count[2];
   assign bus.busy = state == RUN;
   assign bus.done = done;
   assign bus.wraps = wraps;
endmodule

// File: tb/tb_counter_seq.sv
// tb_counter_seq: directed scenarios plus random stimulus against a behavioural model
module tb_counter_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_checks = 0;
   int n_fail = 0;
   int m_st, m_cnt, m_dir, m_os, m_lim, m_wr, m_done;
   counter_seq_if cif ();
   counter_seq dut (.clk(clk), .rst(rst), .bus(cif));
   always #5 clk = ~clk;
   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask
   task automatic model_reset();
      m_st = 0; m_cnt = 0; m_dir = 0; m_os = 0; m_lim = 0; m_wr = 0; m_done = 0;
   endtask
   // m_st: 0 idle, 1 run, 2 pause, 3 done
   task automatic model_step();
      int nxt;
      bit adv;
      adv = 0;
      m_done = 0;
      if (m_st == 0 || m_st == 3) begin
         if (cif.start) begin
            m_dir = int'(cif.dir); m_os = int'(cif.oneshot); m_lim = int'(cif.limit);
            m_cnt = m_dir ? m_lim : 0; m_wr = 0; m_st = 1;
         end
      end else if (m_st == 1) begin
         if (cif.stop) m_st = 2; else adv = 1;
      end else begin
         if (cif.stop) begin m_st = 0; m_cnt = 0; end
         else if (cif.start) m_st = 1;
         else if (cif.step) adv = 1;
      end
      if (adv) begin
         nxt = m_dir ? m_cnt - 1 : m_cnt + 1;
         if (nxt < 0 || nxt > m_lim) begin
            m_done = 1;
            m_wr = (m_wr + 1 > 15) ? 15 : m_wr + 1;
            if (m_os) m_st = 3; else m_cnt = m_dir ? m_lim : 0;
         end else m_cnt = nxt;
      end
   endtask
   task automatic compare(input string tag);
      check({tag, "_q"}, int'({cif.Q2, cif.Q1, cif.Q0}), m_cnt);
      check({tag, "_busy"}, int'(cif.busy), int'(m_st == 1));
      check({tag, "_done"}, int'(cif.done), m_done);
      check({tag, "_wraps"}, int'(cif.wraps), m_wr);
   endtask
   task automatic tick(input string tag);
      @(posedge clk);
      if (rst) model_reset(); else model_step();
      #1;
      compare(tag);
   endtask
   task automatic set_in(input bit sa, input bit so, input bit se, input bit d, input bit os, input int lim);
      cif.start = sa; cif.stop = so; cif.step = se; cif.dir = d; cif.oneshot = os; cif.limit = 3'(lim);
   endtask
   initial begin
      int ndone;
      set_in(0, 0, 0, 0, 0, 0);
      model_reset();
      tick("reset");
      tick("reset");
      rst = 1'b0;
      tick("idle");
      set_in(1, 0, 0, 0, 0, 5);
      tick("cont_start");
      cif.start = 0;
      repeat (3) tick("cont_pre_rst");
      check("count_at_3", int'({cif.Q2, cif.Q1, cif.Q0}), 3);
      #2 rst = 1'b1;
      #1;
      check("async_rst_q", int'({cif.Q2, cif.Q1, cif.Q0}), 0);
      check("async_rst_busy", int'(cif.busy), 0);
      check("async_rst_wraps", int'(cif.wraps), 0);
      model_reset();
      #1 rst = 1'b0;
      tick("post_rst_idle");
      tick("post_rst_idle");
      set_in(1, 0, 0, 0, 0, 5);
      tick("cont_start");
      cif.start = 0;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         tick("cont_run");
         ndone += int'(cif.done);
      end
      check("cont_wraps_12", int'(cif.wraps), 2);
      check("cont_done_cnt", ndone, 2);
      cif.stop = 1;
      tick("abort1");
      tick("abort2");
      set_in(1, 0, 0, 1, 1, 3);
      tick("down_start");
      cif.start = 0;
      repeat (5) tick("down_run");
      check("down_hold", int'({cif.Q2, cif.Q1, cif.Q0}), 0);
      check("down_busy", int'(cif.busy), 0);
      cif.step = 1;
      tick("down_step_ign");
      set_in(1, 0, 0, 0, 0, 7);
      tick("pause_start");
      cif.start = 0;
      repeat (2) tick("pause_run");
      cif.stop = 1;
      tick("pause_stop");
      check("pause_hold2", int'({cif.Q2, cif.Q1, cif.Q0}), 2);
      cif.stop = 0; cif.step = 1;
      repeat (2) tick("pause_step");
      check("step_to_4", int'({cif.Q2, cif.Q1, cif.Q0}), 4);
      cif.step = 0; cif.start = 1;
      tick("resume");
      cif.start = 0;
      tick("resume_run");
      check("resume_5", int'({cif.Q2, cif.Q1, cif.Q0}), 5);
      cif.start = 1; cif.stop = 1;
      tick("stop_wins");
      check("stop_wins_busy", int'(cif.busy), 0);
      cif.start = 0;
      tick("abort_pause");
      set_in(1, 0, 0, 0, 0, 0);
      tick("lim0_start");
      cif.start = 0;
      repeat (20) tick("lim0_run");
      check("lim0_wraps_sat", int'(cif.wraps), 15);
      check("lim0_done", int'(cif.done), 1);
      cif.stop = 1;
      tick("lim0_stop");
      tick("lim0_abort");
      set_in(1, 0, 0, 0, 0, 5);
      tick("latch_start");
      cif.start = 0; cif.limit = 3'd2;
      repeat (5) tick("latch_run");
      check("latch_reach5", int'({cif.Q2, cif.Q1, cif.Q0}), 5);
      tick("latch_wrap");
      check("latch_wrap_done", int'(cif.done), 1);
      cif.stop = 1;
      tick("latch_stop");
      tick("latch_abort");
      check("latch_idle_q", int'({cif.Q2, cif.Q1, cif.Q0}), 0);
      cif.stop = 0;
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(99) == 0);
         set_in($urandom_range(7) == 0, $urandom_range(9) == 0, $urandom_range(3) == 0,
                1'($urandom), 1'($urandom), int'($urandom_range(7)));
         tick("rand");
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
